axi_lite_periph_slave: RTL and testbench

//  AXI4-Lite responder for the CPU peripheral window (base 32'h44A00000). It terminates the

---
 rtl/periph_axi_pkg.sv | 37 +++
 rtl/axi_lite_reg_bank.sv | 58 +++++
 rtl/axi_lite_periph_slave.sv | 160 ++++++++++++++++
 tb/tb_axi_lite_periph_slave.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_axi_pkg.sv
// Shared constants, state encodings and helpers for the peripheral AXI4-Lite slave.
// Holds response codes, the CPU peripheral window bounds and the FSM state types.
package periph_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] PERIPH_BASE  = 32'h44A00000;
    localparam logic [31:0] PERIPH_LIMIT = 32'h44A10000;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Bytes of new_val with strb set replace the matching bytes of old_val.
    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Register storage for the peripheral slave: byte-strobed bus writes, a full-word
// hardware write port, a combinational read mux and the flattened register view.
// Ports: clk/rst; bus_we/bus_idx/bus_data/bus_strb (bus write, index already
//   range-checked); hw_we/hw_idx/hw_data (user-logic write, out-of-range ignored);
//   rd_idx/rd_data (combinational read); reg_out (reg i at bits [32i+31:32i]).
module axi_lite_reg_bank
    import periph_axi_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bus_we,
    input  logic [5:0]               bus_idx,
    input  logic [31:0]              bus_data,
    input  logic [3:0]               bus_strb,
    input  logic                     hw_we,
    input  logic [5:0]               hw_idx,
    input  logic [31:0]              hw_data,
    input  logic [5:0]               rd_idx,
    output logic [31:0]              rd_data,
    output logic [NUM_REGS*32-1:0]   reg_out
);

    logic [31:0] regs [NUM_REGS];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic bus_hit;
        logic hw_hit;

        assign bus_hit = bus_we && (bus_idx == 6'(i));
        assign hw_hit  = hw_we && (hw_idx == 6'(i));

        // Hardware data forms the base word; strobed bus bytes land on top of it,
        // so the bus wins on every byte it actually writes.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                regs[i] <= '0;
            end else if (bus_hit || hw_hit) begin
                regs[i] <= strb_merge(hw_hit ? hw_data : regs[i],
                                      bus_data,
                                      bus_hit ? bus_strb : 4'b0000);
            end
        end

        assign reg_out[32*i +: 32] = regs[i];
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == 6'(i)) begin
                rd_data = regs[i];
            end
        end
    end

endmodule

// File: rtl/axi_lite_periph_slave.sv
// AXI4-Lite responder for the CPU peripheral window exposing a bank of 32-bit registers.
// Ports: Clk/Rst; AXI4-Lite AW/W/B and AR/R channels (S_*); RegOut flattened register
//   contents; HwWrEn/HwWrIdx/HwWrData user-logic full-word register write port.
module axi_lite_periph_slave
    import periph_axi_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 16
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [ADDR_W-1:0]        S_AWADDR,
    input  logic                     S_AWVALID,
    output logic                     S_AWREADY,
    input  logic [31:0]              S_WDATA,
    input  logic [3:0]               S_WSTRB,
    input  logic                     S_WVALID,
    output logic                     S_WREADY,
    output logic [1:0]               S_BRESP,
    output logic                     S_BVALID,
    input  logic                     S_BREADY,
    input  logic [ADDR_W-1:0]        S_ARADDR,
    input  logic                     S_ARVALID,
    output logic                     S_ARREADY,
    output logic [31:0]              S_RDATA,
    output logic [1:0]               S_RRESP,
    output logic                     S_RVALID,
    input  logic                     S_RREADY,
    output logic [NUM_REGS*32-1:0]   RegOut,
    input  logic                     HwWrEn,
    input  logic [5:0]               HwWrIdx,
    input  logic [31:0]              HwWrData
);

    // Word offset of the window base within the significant address bits.
    localparam logic [ADDR_W-3:0] BASE_WORD = PERIPH_BASE[ADDR_W-1:2];

    logic [ADDR_W-3:0] aw_word;
    logic [ADDR_W-3:0] ar_word;
    logic              aw_ok;
    logic              ar_ok;
    logic              unused;

    assign aw_word = S_AWADDR[ADDR_W-1:2] - BASE_WORD;
    assign ar_word = S_ARADDR[ADDR_W-1:2] - BASE_WORD;
    assign aw_ok   = 32'(aw_word) < 32'(NUM_REGS);
    assign ar_ok   = 32'(ar_word) < 32'(NUM_REGS);
    assign unused  = ^{S_AWADDR[1:0], S_ARADDR[1:0]};

    w_state_t    w_state, w_next;
    r_state_t    r_state, r_next;
    logic        aw_hs;
    logic        ar_hs;
    logic [1:0]  bresp;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic [31:0] bank_rd;

    // Write channel: AW and W are accepted together only.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next = w_state;
        aw_hs  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (S_AWVALID && S_WVALID) begin
                    aw_hs  = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (S_BREADY) begin
                    w_next = W_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bresp <= RESP_OKAY;
        end else if (aw_hs) begin
            bresp <= aw_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Read channel, independent of the write side.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next = r_state;
        ar_hs  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (S_ARVALID) begin
                    ar_hs  = 1'b1;
                    r_next = R_DATA;
                end
            end
            R_DATA: begin
                if (S_RREADY) begin
                    r_next = R_IDLE;
                end
            end
        endcase
    end

    // Sampled from the mux before the write edge lands, so a same-cycle
    // write to the same register returns the old value.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rdata <= '0;
            rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata <= ar_ok ? bank_rd : 32'h0;
            rresp <= ar_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    axi_lite_reg_bank #(
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clk      (Clk),
        .rst      (Rst),
        .bus_we   (aw_hs && aw_ok),
        .bus_idx  (6'(aw_word)),
        .bus_data (S_WDATA),
        .bus_strb (S_WSTRB),
        .hw_we    (HwWrEn),
        .hw_idx   (HwWrIdx),
        .hw_data  (HwWrData),
        .rd_idx   (6'(ar_word)),
        .rd_data  (bank_rd),
        .reg_out  (RegOut)
    );

    // Ready is held low while reset is asserted even though the FSMs sit in idle.
    assign S_AWREADY = aw_hs && !Rst;
    assign S_WREADY  = aw_hs && !Rst;
    assign S_BVALID  = (w_state == W_RESP);
    assign S_BRESP   = bresp;
    assign S_ARREADY = (r_state == R_IDLE) && !Rst;
    assign S_RVALID  = (r_state == R_DATA);
    assign S_RDATA   = rdata;
    assign S_RRESP   = rresp;

endmodule

// File: tb/tb_axi_lite_periph_slave.sv
// Self-checking bench for axi_lite_periph_slave: directed AXI4-Lite transactions
// against a transaction-level register model, plus hand-computed expectations.
module tb_axi_lite_periph_slave;

    localparam int NR = 16;
    localparam int AW = 16;

    logic               Clk;
    logic               Rst;
    logic [AW-1:0]      S_AWADDR;
    logic               S_AWVALID;
    logic               S_AWREADY;
    logic [31:0]        S_WDATA;
    logic [3:0]         S_WSTRB;
    logic               S_WVALID;
    logic               S_WREADY;
    logic [1:0]         S_BRESP;
    logic               S_BVALID;
    logic               S_BREADY;
    logic [AW-1:0]      S_ARADDR;
    logic               S_ARVALID;
    logic               S_ARREADY;
    logic [31:0]        S_RDATA;
    logic [1:0]         S_RRESP;
    logic               S_RVALID;
    logic               S_RREADY;
    logic [NR*32-1:0]   RegOut;
    logic               HwWrEn;
    logic [5:0]         HwWrIdx;
    logic [31:0]        HwWrData;

    axi_lite_periph_slave #(
        .NUM_REGS (NR),
        .ADDR_W   (AW)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .S_AWADDR  (S_AWADDR),
        .S_AWVALID (S_AWVALID),
        .S_AWREADY (S_AWREADY),
        .S_WDATA   (S_WDATA),
        .S_WSTRB   (S_WSTRB),
        .S_WVALID  (S_WVALID),
        .S_WREADY  (S_WREADY),
        .S_BRESP   (S_BRESP),
        .S_BVALID  (S_BVALID),
        .S_BREADY  (S_BREADY),
        .S_ARADDR  (S_ARADDR),
        .S_ARVALID (S_ARVALID),
        .S_ARREADY (S_ARREADY),
        .S_RDATA   (S_RDATA),
        .S_RRESP   (S_RRESP),
        .S_RVALID  (S_RVALID),
        .S_RREADY  (S_RREADY),
        .RegOut    (RegOut),
        .HwWrEn    (HwWrEn),
        .HwWrIdx   (HwWrIdx),
        .HwWrData  (HwWrData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: register array plus one outstanding response per channel.
    logic [31:0] m [NR] = '{default: 32'h0};
    logic        b_pend = 1'b0;
    logic        r_pend = 1'b0;
    logic [1:0]  b_resp = 2'b00;
    logic [1:0]  r_resp = 2'b00;
    logic [31:0] r_data = 32'h0;

    always @(posedge Clk or posedge Rst) begin : model
        logic aw_fire;
        logic ar_fire;
        if (Rst) begin
            m      = '{default: 32'h0};
            b_pend = 1'b0;
            r_pend = 1'b0;
            b_resp = 2'b00;
            r_resp = 2'b00;
            r_data = 32'h0;
        end else begin
            aw_fire = !b_pend && S_AWVALID && S_WVALID;
            ar_fire = !r_pend && S_ARVALID;
            if (ar_fire) begin
                r_pend = 1'b1;
                if (int'(S_ARADDR[AW-1:2]) < NR) begin
                    r_data = m[S_ARADDR[5:2]];
                    r_resp = 2'b00;
                end else begin
                    r_data = 32'h0;
                    r_resp = 2'b10;
                end
            end else if (r_pend && S_RREADY) begin
                r_pend = 1'b0;
            end
            if (HwWrEn && int'(HwWrIdx) < NR) begin
                m[HwWrIdx[3:0]] = HwWrData;
            end
            if (aw_fire) begin
                b_pend = 1'b1;
                if (int'(S_AWADDR[AW-1:2]) < NR) begin
                    for (int b = 0; b < 4; b++) begin
                        if (S_WSTRB[b]) begin
                            m[S_AWADDR[5:2]][8*b +: 8] = S_WDATA[8*b +: 8];
                        end
                    end
                    b_resp = 2'b00;
                end else begin
                    b_resp = 2'b10;
                end
            end else if (b_pend && S_BREADY) begin
                b_pend = 1'b0;
            end
        end
    end

    always @(negedge Clk) begin : compare
        chk("awready", 32'(S_AWREADY), 32'(!Rst && !b_pend && S_AWVALID && S_WVALID));
        chk("wready", 32'(S_WREADY), 32'(!Rst && !b_pend && S_AWVALID && S_WVALID));
        chk("arready", 32'(S_ARREADY), 32'(!Rst && !r_pend));
        chk("bvalid", 32'(S_BVALID), 32'(b_pend));
        chk("rvalid", 32'(S_RVALID), 32'(r_pend));
        if (b_pend) begin
            chk("bresp", 32'(S_BRESP), 32'(b_resp));
        end
        if (r_pend) begin
            chk("rdata", S_RDATA, r_data);
            chk("rresp", 32'(S_RRESP), 32'(r_resp));
        end
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("regout[%0d]", i), RegOut[32*i +: 32], m[i]);
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int wdelay, input int bdelay,
                            output logic [1:0] resp);
        logic done;
        @(posedge Clk);
        #1;
        S_AWADDR  = a;
        S_AWVALID = 1'b1;
        S_BREADY  = 1'b0;
        if (wdelay > 0) begin
            repeat (wdelay) begin
                @(negedge Clk);
                chk("aw_alone_no_ready", 32'(S_AWREADY), 32'h0);
            end
            @(posedge Clk);
            #1;
        end
        S_WDATA  = d;
        S_WSTRB  = s;
        S_WVALID = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge Clk);
            if (S_AWREADY) done = 1'b1;
        end
        chk("aw_handshake", 32'(done), 32'h1);
        @(posedge Clk);
        #1;
        S_AWVALID = 1'b0;
        S_WVALID  = 1'b0;
        @(negedge Clk);
        chk("bvalid_next_cycle", 32'(S_BVALID), 32'h1);
        resp = S_BRESP;
        repeat (bdelay) @(negedge Clk);
        S_BREADY = 1'b1;
        @(posedge Clk);
        #1;
        S_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int rdelay,
                           output logic [31:0] data, output logic [1:0] resp);
        logic done;
        @(posedge Clk);
        #1;
        S_ARADDR  = a;
        S_ARVALID = 1'b1;
        S_RREADY  = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge Clk);
            if (S_ARREADY) done = 1'b1;
        end
        chk("ar_handshake", 32'(done), 32'h1);
        @(posedge Clk);
        #1;
        S_ARVALID = 1'b0;
        @(negedge Clk);
        chk("rvalid_next_cycle", 32'(S_RVALID), 32'h1);
        data = S_RDATA;
        resp = S_RRESP;
        repeat (rdelay) @(negedge Clk);
        S_RREADY = 1'b1;
        @(posedge Clk);
        #1;
        S_RREADY = 1'b0;
    endtask

    logic [1:0]  bresp_got;
    logic [1:0]  rresp_got;
    logic [31:0] rdata_got;

    initial begin
        Rst       = 1'b0;
        S_AWADDR  = '0;
        S_AWVALID = 1'b0;
        S_WDATA   = '0;
        S_WSTRB   = '0;
        S_WVALID  = 1'b0;
        S_BREADY  = 1'b0;
        S_ARADDR  = '0;
        S_ARVALID = 1'b0;
        S_RREADY  = 1'b0;
        HwWrEn    = 1'b0;
        HwWrIdx   = '0;
        HwWrData  = '0;
        #1 Rst = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_bvalid", 32'(S_BVALID), 32'h0);
        chk("rst_rvalid", 32'(S_RVALID), 32'h0);
        chk("rst_arready", 32'(S_ARREADY), 32'h0);
        chk("rst_rdata", S_RDATA, 32'h0);
        chk("rst_bresp", 32'(S_BRESP), 32'h0);
        chk("rst_rresp", 32'(S_RRESP), 32'h0);
        chk("rst_regout_zero", 32'(|RegOut), 32'h0);
        Rst = 1'b0;

        // Full-word write then read back.
        do_write(16'h0008, 32'hDEADBEEF, 4'hF, 0, 0, bresp_got);
        chk("t1_bresp", 32'(bresp_got), 32'h0);
        @(negedge Clk);
        chk("t1_regout2", RegOut[95:64], 32'hDEADBEEF);
        chk("t1_model2", m[2], 32'hDEADBEEF);
        do_read(16'h0008, 0, rdata_got, rresp_got);
        chk("t1_rdata", rdata_got, 32'hDEADBEEF);
        chk("t1_rresp", 32'(rresp_got), 32'h0);

        // Partial strobes; low address bits ignored on the read.
        do_write(16'h0008, 32'h11223344, 4'b0101, 0, 0, bresp_got);
        do_read(16'h000B, 2, rdata_got, rresp_got);
        chk("t2_rdata", rdata_got, 32'hDE22BE44);

        // AW leads W by 5 cycles; BREADY held off 3 cycles.
        do_write(16'h0010, 32'h01020304, 4'hF, 5, 3, bresp_got);
        chk("t3_bresp", 32'(bresp_got), 32'h0);
        @(negedge Clk);
        chk("t3_bvalid_done", 32'(S_BVALID), 32'h0);
        chk("t3_regout4", RegOut[159:128], 32'h01020304);

        // Out-of-range accesses.
        do_write(16'h0040, 32'hFFFFFFFF, 4'hF, 0, 1, bresp_got);
        chk("t4_bresp", 32'(bresp_got), 32'h2);
        do_read(16'h0040, 0, rdata_got, rresp_got);
        chk("t4_rdata", rdata_got, 32'h0);
        chk("t4_rresp", 32'(rresp_got), 32'h2);
        do_write(16'h0FFC, 32'h12345678, 4'hF, 0, 0, bresp_got);
        chk("t4_bresp_high", 32'(bresp_got), 32'h2);
        @(posedge Clk);
        #1;
        HwWrEn   = 1'b1;
        HwWrIdx  = 6'd20;
        HwWrData = 32'hA5A5A5A5;
        @(posedge Clk);
        #1;
        HwWrEn = 1'b0;
        @(negedge Clk);
        chk("t4_regout2_kept", RegOut[95:64], 32'hDE22BE44);

        // Same-cycle read and write of reg 1.
        do_write(16'h0004, 32'h00000005, 4'hF, 0, 0, bresp_got);
        fork
            do_write(16'h0004, 32'h00000009, 4'hF, 0, 0, bresp_got);
            do_read(16'h0004, 0, rdata_got, rresp_got);
        join
        chk("t5_read_old", rdata_got, 32'h00000005);
        @(negedge Clk);
        chk("t5_reg1_new", RegOut[63:32], 32'h00000009);
        fork
            do_write(16'h0004, 32'h000000AA, 4'b0001, 0, 0, bresp_got);
            begin
                @(posedge Clk);
                #1;
                HwWrEn   = 1'b1;
                HwWrIdx  = 6'd1;
                HwWrData = 32'h12345677;
                @(posedge Clk);
                #1;
                HwWrEn = 1'b0;
            end
        join
        @(negedge Clk);
        chk("t5_bus_hw_merge", RegOut[63:32], 32'h123456AA);

        // Reset with both responses pending.
        @(posedge Clk);
        #1;
        S_AWADDR  = 16'h000C;
        S_WDATA   = 32'hCAFEF00D;
        S_WSTRB   = 4'hF;
        S_AWVALID = 1'b1;
        S_WVALID  = 1'b1;
        S_ARADDR  = 16'h0008;
        S_ARVALID = 1'b1;
        S_BREADY  = 1'b0;
        S_RREADY  = 1'b0;
        @(posedge Clk);
        #1;
        S_AWVALID = 1'b0;
        S_WVALID  = 1'b0;
        S_ARVALID = 1'b0;
        @(negedge Clk);
        chk("t6_bvalid_pending", 32'(S_BVALID), 32'h1);
        chk("t6_rvalid_pending", 32'(S_RVALID), 32'h1);
        #2 Rst = 1'b1;
        #1;
        chk("t6_bvalid_drop", 32'(S_BVALID), 32'h0);
        chk("t6_rvalid_drop", 32'(S_RVALID), 32'h0);
        chk("t6_regout_zero", 32'(|RegOut), 32'h0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        do_write(16'h000C, 32'h0BADCAFE, 4'hF, 0, 0, bresp_got);
        chk("t6_post_bresp", 32'(bresp_got), 32'h0);
        do_read(16'h000C, 1, rdata_got, rresp_got);
        chk("t6_post_rdata", rdata_got, 32'h0BADCAFE);
        chk("t6_post_rresp", 32'(rresp_got), 32'h0);

        repeat (3) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
